// File: rtl/memaccess.sv
// memaccess: MEM-stage load/store unit. It turns the EX/MEM instruction into a
// single data-bus transaction, freezes the upstream pipeline while the bus is
// busy, formats load data for MEM/WB, and reports misaligned accesses and bus
// timeouts as one-cycle pulses.
module memaccess (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_memrd,
    input  logic        i_memwr,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic        o_stall,
    output logic [31:0] o_out,
    output logic        o_misalign,
    output logic        o_buserr,
    output logic        o_mreq,
    output logic        o_mwe,
    output logic [31:0] o_maddr,
    output logic [31:0] o_mwdata,
    output logic [3:0]  o_mbe,
    input  logic        i_mack,
    input  logic [31:0] i_mrdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        is_mem;
    logic        aligned;
    logic        access;
    logic        timeout;
    logic        store_r;
    logic [7:0]  wdog;

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                             input logic [1:0]  ofs,
                                             input logic [1:0]  size,
                                             input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = ofs[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return {{24{sext & b[7]}}, b};
            2'b01:   return {{16{sext & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    // Little-endian byte enables for the addressed bytes.
    function automatic logic [3:0] byte_en(input logic [1:0] ofs,
                                           input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << ofs;
            2'b01:   return ofs[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across every lane so the byte enables pick it.
    function automatic logic [31:0] store_data(input logic [31:0] wdata,
                                               input logic [1:0]  size);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Decode the request and its alignment; a store wins when both are set.
    always_comb begin
        is_mem  = i_valid & (i_memrd | i_memwr);
        case (i_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~i_addr[0];
            default: aligned = (i_addr[1:0] == 2'b00);
        endcase
        access  = is_mem & aligned;
        // An ack in the final watchdog cycle still wins over the abort.
        timeout = (wdog == 8'hFF) & ~i_mack;
    end

    // State register; reset abandons any bus cycle in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: one bus cycle per instruction, DONE releases the stall.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = REQ;
            REQ:     if (i_mack || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the stall must rise in the same cycle the access is seen.
    always_comb begin
        o_stall    = 1'b0;
        o_mreq     = 1'b0;
        o_misalign = 1'b0;
        case (state)
            IDLE: begin
                o_stall    = access & rst_n;
                o_misalign = is_mem & ~aligned & rst_n;
            end
            REQ: begin
                o_stall = 1'b1;
                o_mreq  = 1'b1;
            end
            default: ;
        endcase
        o_mwe   = o_mreq & store_r;
        o_maddr = {i_addr[31:2], 2'b00};
    end

    // Bus attributes latched at REQ entry, watchdog, load result and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mbe    <= 4'b0000;
            o_mwdata <= 32'h0;
            store_r  <= 1'b0;
            wdog     <= 8'h00;
            o_out    <= 32'h0;
            o_buserr <= 1'b0;
        end else begin
            o_buserr <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        o_mbe    <= byte_en(i_addr[1:0], i_size);
                        o_mwdata <= store_data(i_wdata, i_size);
                        store_r  <= i_memwr;
                        wdog     <= 8'h00;
                    end
                end
                REQ: begin
                    if (i_mack) begin
                        if (!store_r) o_out <= fmt_load(i_mrdata, i_addr[1:0], i_size, i_sext);
                    end else if (timeout) begin
                        o_buserr <= 1'b1;
                        if (!store_r) o_out <= 32'h0;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memaccess.md
MEMACCESS -- requirements
Module: memaccess

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port i_valid  in  1  EX/MEM register holds a live instruction.
REQ-004 SHALL have port i_addr  in  32  byte address (ALU result).
REQ-005 SHALL have port i_wdata  in  32  store data, right-justified.
REQ-006 SHALL have ports i_memrd, i_memwr  in  1 each  load / store request; both high is treated as store.
REQ-007 SHALL have port i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 SHALL have port i_sext  in  1  sign-extend loads when high, zero-extend when low.
REQ-009 SHALL have port o_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-010 SHALL have port o_out  out  32  formatted load data feeding MEM/WB i_out.
REQ-011 SHALL have ports o_misalign, o_buserr  out  1 each  single-cycle fault pulses.
REQ-012 SHALL have ports o_mreq, o_mwe  out  1 each; o_maddr  out  32; o_mwdata  out  32; o_mbe  out  4  data memory bus.
REQ-013 SHALL have ports i_mack  in  1; i_mrdata  in  32  memory acknowledge and read data.

Function
REQ-014 FSM SHALL have states IDLE, REQ, DONE.
REQ-015 Access SHALL be i_valid & (i_memrd | i_memwr) & aligned.
REQ-016 Aligned SHALL mean: byte always; half needs i_addr[0]=0; word needs i_addr[1:0]=00.
REQ-017 IDLE: on access, o_stall SHALL be 1 combinationally in the same cycle; next state REQ.
REQ-018 IDLE: misaligned request SHALL pulse o_misalign for that cycle, issue no bus cycle, keep o_stall 0, and leave o_out unchanged.
REQ-019 REQ: o_mreq SHALL be 1. o_maddr = {i_addr[31:2],2'b00}. o_mwe = store. o_mbe and o_mwdata SHALL be registered at REQ entry and held stable until ack.
REQ-020 o_mbe SHALL be: byte 4'b0001<<addr[1:0]; half addr[1] ? 1100 : 0011; word 1111 (little-endian).
REQ-021 o_mwdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-022 REQ: i_mack sampled high SHALL move to DONE. On load, it SHALL register into o_out the selected lane of i_mrdata, extended per i_sext to 32 bits.
REQ-023 REQ SHALL keep o_stall 1. DONE SHALL drive o_stall 0 and o_mreq 0, return to IDLE next cycle, and not re-trigger the same instruction.
REQ-024 Watchdog: an 8-bit counter SHALL clear on REQ entry and increment each REQ cycle without ack. At count 255 without ack it SHALL abort to DONE, pulse o_buserr, and set o_out=0 for a load.
REQ-025 i_mack outside REQ SHALL be ignored; ack and timeout in the same cycle SHALL count as ack.
REQ-026 Non-memory or invalid instructions SHALL leave o_stall 0, o_mreq 0, and o_out held.
REQ-027 Store completion SHALL leave o_out unchanged.

Reset
REQ-028 rst_n low SHALL immediately force IDLE. It SHALL also force o_mreq, o_mwe, o_stall, o_misalign, o_buserr to 0, o_out to 0, o_mbe to 0, o_mwdata to 0, and the watchdog to 0.
REQ-029 Reset asserted during REQ SHALL drop o_mreq asynchronously, abandon the access, and resume in IDLE after release.

Verification
REQ-030 Load word addr 0x100, mack after 2 cycles, mrdata 0xDEADBEEF -> o_stall high 3 cycles, o_out=0xDEADBEEF in DONE, then stall low.
REQ-031 Load byte addr 0x103, sext=1, mrdata 0x80FF0011 -> o_mbe 1000, o_out=0xFFFFFF80; with sext=0, o_out=0x00000080.
REQ-032 Store half addr 0x202, wdata 0x1234ABCD -> o_mbe 1100, o_mwdata 0xABCDABCD, o_mwe 1.
REQ-033 Load word addr 0x101 -> o_misalign one-cycle pulse, o_mreq never asserted, o_stall 0.
REQ-034 Load with mack never asserted -> o_buserr pulse after 255 REQ cycles, o_out=0, stall released.
REQ-035 rst_n low mid-REQ -> o_mreq 0 same cycle, o_out 0. After release, a fresh load completes normally.
